// File: rtl/program_memory_responder_if.sv
// Read bus between the memory arbiter (master) and the program memory (slave).
// The broadcast signals let every basic-block cache snoop served words.
interface program_memory_responder_if #(
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic                         mem_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr;
  logic                         mem_ready;
  logic [MEMORY_WIDTH-1:0]      mem_data;
  logic                         mem_broadcast_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_broadcast_addr;

  modport master (
    output mem_valid, mem_addr,
    input  mem_ready, mem_data, mem_broadcast_valid, mem_broadcast_addr
  );

  modport slave (
    input  mem_valid, mem_addr,
    output mem_ready, mem_data, mem_broadcast_valid, mem_broadcast_addr
  );
endinterface

// File: rtl/program_memory_responder.sv
// Program memory responder: single-port synchronous RAM serving one read at a
// time with a fixed latency, plus a host write port usable only while idle.
// All outputs are registered; the ready pulse is produced on entry to RESP.
module program_memory_responder #(
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int READ_LATENCY      = 2,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  program_memory_responder_if.slave    mem,
  input  logic                         wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                         wr_ready,
  output logic                         busy,
  output logic [COUNT_WIDTH-1:0]       rd_count
);

  localparam int         DEPTH    = 2 ** MEMORY_ADDR_WIDTH;
  localparam bit         LAT_ONE  = (READ_LATENCY == 1);
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt);
    if (cnt == {COUNT_WIDTH{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + COUNT_WIDTH'(1);
    end
  endfunction

  logic [MEMORY_WIDTH-1:0]      ram [DEPTH];

  state_t                       state_r;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_r;
  logic [3:0]                   lat_cnt_r;
  logic                         mem_ready_r;
  logic                         bvalid_r;
  logic [MEMORY_ADDR_WIDTH-1:0] baddr_r;
  logic [MEMORY_WIDTH-1:0]      data_r;
  logic                         busy_r;
  logic                         wr_ready_r;
  logic [COUNT_WIDTH-1:0]       rd_count_r;

  logic                         go_resp_s;
  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr_s;
  logic                         wr_accept_s;

  // Writes are only accepted in IDLE; they take priority over a pending read.
  always_comb begin
    wr_accept_s = 1'b0;
    if ((state_r == ST_IDLE) && wr_valid) begin
      wr_accept_s = 1'b1;
    end else begin
      wr_accept_s = 1'b0;
    end
  end

  // Decide when the next edge enters RESP and which address is read then.
  // With unit latency the read happens at the sample edge, straight from the bus.
  always_comb begin
    go_resp_s = 1'b0;
    rd_addr_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        rd_addr_s = mem.mem_addr;
        if (LAT_ONE && !wr_valid && mem.mem_valid) begin
          go_resp_s = 1'b1;
        end else begin
          go_resp_s = 1'b0;
        end
      end
      ST_READ: begin
        if (lat_cnt_r == 4'd1) begin
          go_resp_s = 1'b1;
        end else begin
          go_resp_s = 1'b0;
        end
      end
      default: begin
        go_resp_s = 1'b0;
      end
    endcase
  end

  // Host write into the program RAM; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // Control FSM with registered response, broadcast and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      lat_cnt_r   <= 4'd0;
      mem_ready_r <= 1'b0;
      bvalid_r    <= 1'b0;
      baddr_r     <= '0;
      data_r      <= '0;
      busy_r      <= 1'b0;
      wr_ready_r  <= 1'b1;
      rd_count_r  <= '0;
    end else begin
      mem_ready_r <= 1'b0;
      bvalid_r    <= 1'b0;
      if (go_resp_s) begin
        mem_ready_r <= 1'b1;
        bvalid_r    <= 1'b1;
        data_r      <= ram[rd_addr_s];
        baddr_r     <= rd_addr_s;
        rd_count_r  <= sat_inc(rd_count_r);
      end
      case (state_r)
        ST_IDLE: begin
          if (!wr_valid && mem.mem_valid) begin
            addr_r     <= mem.mem_addr;
            lat_cnt_r  <= LAT_INIT;
            busy_r     <= 1'b1;
            wr_ready_r <= 1'b0;
            state_r    <= LAT_ONE ? ST_RESP : ST_READ;
          end
        end
        ST_READ: begin
          lat_cnt_r <= lat_cnt_r - 4'd1;
          if (go_resp_s) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          wr_ready_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          wr_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign mem.mem_ready           = mem_ready_r;
  assign mem.mem_data            = data_r;
  assign mem.mem_broadcast_valid = bvalid_r;
  assign mem.mem_broadcast_addr  = baddr_r;
  assign wr_ready                = wr_ready_r;
  assign busy                    = busy_r;
  assign rd_count                = rd_count_r;

endmodule

// File: tb/tb_program_memory_responder.sv
// Bench for program_memory_responder: two instances (latency 2 / 16-bit count,
// latency 1 / 2-bit count) share one stimulus stream; a timeline model predicts
// when each read is served and what every output shows in every cycle.
module tb_program_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [10:0] mem_addr = 11'd0;
  logic        wr_valid = 1'b0;
  logic [10:0] wr_addr = 11'd0;
  logic [19:0] wr_data = 20'd0;

  logic        wr_ready_a, busy_a, wr_ready_b, busy_b;
  logic [15:0] rd_count_a;
  logic [1:0]  rd_count_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  program_memory_responder_if #(.MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11)) if_a ();
  program_memory_responder_if #(.MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11)) if_b ();

  assign if_a.mem_valid = mem_valid;
  assign if_a.mem_addr  = mem_addr;
  assign if_b.mem_valid = mem_valid;
  assign if_b.mem_addr  = mem_addr;

  program_memory_responder #(.MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11),
                             .READ_LATENCY(2), .COUNT_WIDTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .mem(if_a),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_a), .busy(busy_a), .rd_count(rd_count_a)
  );

  program_memory_responder #(.MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11),
                             .READ_LATENCY(1), .COUNT_WIDTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .mem(if_b),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_b), .busy(busy_b), .rd_count(rd_count_b)
  );

  always #5 clk = ~clk;

  // Reference model: per instance, a pending read is served in cycle
  // sample_cycle + latency, and the responder is idle again the cycle after.
  int          lat  [2] = '{2, 1};
  int          cmax [2] = '{65535, 3};
  bit          pend [2];
  int          rdy_at [2];
  logic [10:0] paddr [2];
  int          cnt [2];
  logic [19:0] ldata [2];
  logic [10:0] laddr [2];
  logic [19:0] rmem [2][2048];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k]  = 1'b0;
      rdy_at[k] = 0;
      cnt[k]   = 0;
      ldata[k] = 20'd0;
      laddr[k] = 11'd0;
    end
  endtask

  task automatic check_dut(input int k);
    logic rdy, bv, bsy, wrr;
    logic [10:0] ba;
    logic [19:0] d;
    logic [15:0] rc;
    bit serving, busy_e;
    string nm;
    if (k == 0) begin
      nm = "lat2"; rdy = if_a.mem_ready; bv = if_a.mem_broadcast_valid;
      ba = if_a.mem_broadcast_addr; d = if_a.mem_data;
      bsy = busy_a; wrr = wr_ready_a; rc = rd_count_a;
    end else begin
      nm = "lat1"; rdy = if_b.mem_ready; bv = if_b.mem_broadcast_valid;
      ba = if_b.mem_broadcast_addr; d = if_b.mem_data;
      bsy = busy_b; wrr = wr_ready_b; rc = {14'd0, rd_count_b};
    end
    serving = pend[k] && (cyc == rdy_at[k]);
    busy_e  = pend[k] && (cyc <= rdy_at[k]);
    if (serving) begin
      ldata[k] = rmem[k][paddr[k]];
      laddr[k] = paddr[k];
      if (cnt[k] < cmax[k]) cnt[k]++;
    end
    check_eq({nm, ".ready"},    32'(rdy), 32'(serving));
    check_eq({nm, ".bvalid"},   32'(bv),  32'(serving));
    check_eq({nm, ".baddr"},    32'(ba),  32'(laddr[k]));
    check_eq({nm, ".data"},     32'(d),   32'(ldata[k]));
    check_eq({nm, ".busy"},     32'(bsy), 32'(busy_e));
    check_eq({nm, ".wr_ready"}, 32'(wrr), 32'(!busy_e));
    check_eq({nm, ".rd_count"}, 32'(rc),  32'(cnt[k]));
  endtask

  task automatic model_edge(input int k);
    bit idle;
    idle = !pend[k] || (cyc > rdy_at[k]);
    if (idle) begin
      if (wr_valid) begin
        rmem[k][wr_addr] = wr_data;
      end else if (mem_valid) begin
        pend[k]   = 1'b1;
        rdy_at[k] = cyc + lat[k];
        paddr[k]  = mem_addr;
      end
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic do_cycle();
    for (int k = 0; k < 2; k++) check_dut(k);
    for (int k = 0; k < 2; k++) model_edge(k);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    mem_valid = 1'b0;
    wr_valid  = 1'b0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic set_read(input logic v, input logic [10:0] a);
    mem_valid = v;
    mem_addr  = a;
  endtask

  task automatic set_write(input logic v, input logic [10:0] a, input logic [19:0] dval);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = dval;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Preload the low addresses so every read returns known data.
    for (int a = 0; a < 16; a++) begin
      set_write(1'b1, 11'(a), 20'($urandom));
      do_cycle();
    end
    idle_cycles(2);

    // Write then read the next cycle.
    set_write(1'b1, 11'd5, 20'h12345);
    do_cycle();
    set_write(1'b0, 11'd0, 20'd0);
    set_read(1'b1, 11'd5);
    do_cycle();
    idle_cycles(4);

    // Continuous request on one address.
    set_write(1'b1, 11'd7, 20'hABCDE);
    do_cycle();
    set_write(1'b0, 11'd0, 20'd0);
    set_read(1'b1, 11'd7);
    for (int i = 0; i < 10; i++) do_cycle();
    idle_cycles(4);

    // Simultaneous write and read of the same address.
    set_write(1'b1, 11'd9, 20'h00F0F);
    set_read(1'b1, 11'd9);
    do_cycle();
    set_write(1'b0, 11'd0, 20'd0);
    for (int i = 0; i < 3; i++) do_cycle();
    idle_cycles(4);

    // Address change and blocked writes while a read is in flight.
    set_read(1'b1, 11'd3);
    do_cycle();
    set_read(1'b0, 11'd4);
    set_write(1'b1, 11'd3, 20'h55555);
    for (int i = 0; i < 3; i++) do_cycle();
    idle_cycles(2);
    set_read(1'b1, 11'd3);
    do_cycle();
    idle_cycles(4);

    // Reset one cycle into the read: everything clears at once.
    set_read(1'b1, 11'd7);
    do_cycle();
    set_read(1'b0, 11'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("rst.ready_a",  32'(if_a.mem_ready),           32'd0);
    check_eq("rst.bvalid_a", 32'(if_a.mem_broadcast_valid), 32'd0);
    check_eq("rst.baddr_a",  32'(if_a.mem_broadcast_addr),  32'd0);
    check_eq("rst.data_a",   32'(if_a.mem_data),            32'd0);
    check_eq("rst.busy_a",   32'(busy_a),                   32'd0);
    check_eq("rst.count_a",  32'(rd_count_a),               32'd0);
    check_eq("rst.ready_b",  32'(if_b.mem_ready),           32'd0);
    check_eq("rst.busy_b",   32'(busy_b),                   32'd0);
    check_eq("rst.count_b",  32'(rd_count_b),               32'd0);
    model_reset();
    @(negedge clk);
    check_eq("rst.hold_ready_a", 32'(if_a.mem_ready), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Five spaced reads: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      set_read(1'b1, 11'(i));
      do_cycle();
      idle_cycles(3);
    end

    // Random traffic over the preloaded address range.
    for (int i = 0; i < 1500; i++) begin
      set_write(($urandom_range(0, 3) == 0), 11'($urandom_range(0, 15)), 20'($urandom));
      set_read(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)));
      do_cycle();
    end
    idle_cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
